// File: rtl/hucard_pkg.sv
// Shared definitions for the HuCard SRAM arbiter: romsel encodings,
// arbiter FSM states and grant-owner identifiers.
package hucard_pkg;

    // HuCard ROM size selections carried on romsel
    localparam logic [2:0] RomSel1m   = 3'b011;
    localparam logic [2:0] RomSel512k = 3'b010;
    localparam logic [2:0] RomSel384k = 3'b001;
    localparam logic [2:0] RomSel256k = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StAck
    } state_e;

    typedef enum logic {
        OwnerCpu,
        OwnerLd
    } owner_e;

endpackage

// File: rtl/hucard_addr_map.sv
// CPU ROM byte address to SRAM byte address mapping, selected by HuCard size.
// 384KiB images are stored as 256KiB + 128KiB; the upper half of the CPU space
// folds onto the 128KiB tail at 0x40000.
module hucard_addr_map
    import hucard_pkg::*;
(
    input  logic [2:0]  romsel,
    input  logic [19:0] addr,
    output logic [19:0] mapped
);

    // Fold the CPU address into the image according to the card size
    always_comb begin
        mapped = addr;
        case (romsel)
            RomSel1m:   mapped = addr;
            RomSel512k: mapped = {1'b0, addr[18:0]};
            RomSel384k: begin
                if (!addr[19]) begin
                    mapped = {2'b00, addr[17:0]};
                end else begin
                    mapped = {3'b010, addr[16:0]};
                end
            end
            RomSel256k: mapped = {2'b00, addr[17:0]};
            default:    mapped = addr;
        endcase
    end

endmodule

// File: rtl/hucard_sram_arbiter.sv
// Two-port arbiter sharing one asynchronous 16-bit SRAM between the CPU
// (byte reads of HuCard ROM) and a loader (word reads/writes).
// Optional feature: define ARB_FAIR_EN for alternating grants when both
// ports request together; otherwise the CPU has strict priority.
module hucard_sram_arbiter
    import hucard_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  romsel,
    input  logic        cpu_req,
    input  logic [19:0] cpu_addr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [18:0] ld_addr,
    input  logic [15:0] ld_wdata,
    output logic [15:0] ld_rdata,
    output logic        ld_ack,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_I,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [2:0] CntLast = 3'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    owner_e      owner_q;
    logic        we_q;
    logic        byte_hi_q;
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  cpu_rdata_q;
    logic [15:0] ld_rdata_q;

    logic [19:0] cpu_mapped;
    logic        any_req;
    logic        grant;
    logic        grant_cpu;
    logic        access_last;

    hucard_addr_map u_addr_map (
        .romsel (romsel),
        .addr   (cpu_addr),
        .mapped (cpu_mapped)
    );

    assign any_req     = cpu_req | ld_req;
    assign grant       = (state_q == StIdle) && any_req;
    assign access_last = (state_q == StAccess) && (cnt_q == CntLast);

`ifdef ARB_FAIR_EN
    // owner_q doubles as the last-granted port; it resets to the loader so
    // the CPU wins the first contended grant.
    assign grant_cpu = cpu_req && (!ld_req || (owner_q == OwnerLd));
`else
    assign grant_cpu = cpu_req;
`endif

    // State register and ACCESS cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> ACK -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                    cnt_d   = 3'd0;
                end
            end
            StAccess: begin
                if (cnt_q == CntLast) begin
                    state_d = StAck;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Latch owner, direction, address and write data at grant; romsel is
    // only looked at here so a mid-access change cannot disturb the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OwnerLd;
            we_q      <= 1'b0;
            byte_hi_q <= 1'b0;
            addr_q    <= 20'd0;
            wdata_q   <= 16'd0;
        end else if (grant) begin
            if (grant_cpu) begin
                owner_q   <= OwnerCpu;
                we_q      <= 1'b0;
                byte_hi_q <= cpu_mapped[0];
                addr_q    <= {1'b0, cpu_mapped[19:1]};
            end else begin
                owner_q <= OwnerLd;
                we_q    <= ld_we;
                addr_q  <= {1'b0, ld_addr};
                wdata_q <= ld_wdata;
            end
        end
    end

    // Capture read data on the edge closing the last ACCESS cycle; values
    // hold until the next read by the same port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= 8'd0;
            ld_rdata_q  <= 16'd0;
        end else if (access_last && !we_q) begin
            if (owner_q == OwnerCpu) begin
                cpu_rdata_q <= byte_hi_q ? SRAM_DQ_I[15:8] : SRAM_DQ_I[7:0];
            end else begin
                ld_rdata_q <= SRAM_DQ_I;
            end
        end
    end

    // SRAM strobes and completion pulses decoded from the current state
    always_comb begin
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_DQ_OE = 1'b0;
        cpu_ack    = 1'b0;
        ld_ack     = 1'b0;
        unique case (state_q)
            StAccess: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (we_q) begin
                    SRAM_DQ_OE = 1'b1;
                    // First cycle is address setup with WE_N still high
                    SRAM_WE_N  = (cnt_q == 3'd0);
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            StAck: begin
                cpu_ack = (owner_q == OwnerCpu);
                ld_ack  = (owner_q == OwnerLd);
            end
            default: begin
            end
        endcase
    end

    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ_O = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_hucard_sram_arbiter.sv
// Directed bench for hucard_sram_arbiter: one WAIT_CYCLES=1 instance with a
// behavioural SRAM, one WAIT_CYCLES=3 instance for the long-access timing.
module tb_hucard_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  romsel;
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        ld_req;
    logic        ld_we;
    logic [18:0] ld_addr;
    logic [15:0] ld_wdata;
    logic [15:0] ld_rdata;
    logic        ld_ack;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [2:0]  romsel3;
    logic        cpu_req3;
    logic [19:0] cpu_addr3;
    logic [7:0]  cpu_rdata3;
    logic        cpu_ack3;
    logic [15:0] ld_rdata3;
    logic        ld_ack3;
    logic [19:0] sram_addr3;
    logic [15:0] sram_dq_o3;
    logic        sram_dq_oe3;
    logic [15:0] sram_dq_i3;
    logic        ce3_n, oe3_n, we3_n, ub3_n, lb3_n;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [int];

    hucard_sram_arbiter #(.WAIT_CYCLES(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .romsel     (romsel),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_rdata   (ld_rdata),
        .ld_ack     (ld_ack),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ_O  (sram_dq_o),
        .SRAM_DQ_OE (sram_dq_oe),
        .SRAM_DQ_I  (sram_dq_i),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    hucard_sram_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .romsel     (romsel3),
        .cpu_req    (cpu_req3),
        .cpu_addr   (cpu_addr3),
        .cpu_rdata  (cpu_rdata3),
        .cpu_ack    (cpu_ack3),
        .ld_req     (1'b0),
        .ld_we      (1'b0),
        .ld_addr    (19'd0),
        .ld_wdata   (16'd0),
        .ld_rdata   (ld_rdata3),
        .ld_ack     (ld_ack3),
        .SRAM_ADDR  (sram_addr3),
        .SRAM_DQ_O  (sram_dq_o3),
        .SRAM_DQ_OE (sram_dq_oe3),
        .SRAM_DQ_I  (sram_dq_i3),
        .SRAM_CE_N  (ce3_n),
        .SRAM_OE_N  (oe3_n),
        .SRAM_WE_N  (we3_n),
        .SRAM_UB_N  (ub3_n),
        .SRAM_LB_N  (lb3_n)
    );

    assign sram_dq_i3 = 16'h1234;

    // Behavioural SRAM: mid-cycle write and read-data update
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            mem[int'(sram_addr)] = sram_dq_o;
        end
        sram_dq_i = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 16'h0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cpu_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_ack && n < 20);
        if (!cpu_ack) n = -1;
    endtask

    task automatic wait_ld_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ld_ack && n < 20);
        if (!ld_ack) n = -1;
    endtask

    initial begin
        int n;
        int we_low, oe_hi, lacks, cacks, ce_low, ack_at, k;
        logic [19:0] addr_seen;
        logic [2:0] order;

        rst = 1'b1; romsel = 3'b011; cpu_req = 1'b0; cpu_addr = 20'd0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 19'd0; ld_wdata = 16'd0;
        romsel3 = 3'b011; cpu_req3 = 1'b0; cpu_addr3 = 20'd0; sram_dq_i = 16'h0000;
        mem[20'h091A2] = 16'hABCD;
        mem[20'h20000] = 16'h3C96;
        mem[20'h1FFFF] = 16'hBEEF;
        mem[20'h02B3C] = 16'h1122;

        tick();
        tick();
        check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rst_ld_ack", 32'(ld_ack), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_ld_rdata", 32'(ld_rdata), 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                                  sram_dq_oe}), 32'b111110);
        rst = 1'b0;

        // 1MiB CPU read, high lane, 3-cycle latency
        romsel = 3'b011; cpu_addr = 20'h12345; cpu_req = 1'b1;
        tick();
        check("s1_addr", 32'(sram_addr), 32'h091A2);
        check("s1_rd_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                                    sram_dq_oe}), 32'b001000);
        check("s1_ack_c1", 32'(cpu_ack), 32'h0);
        tick();
        check("s1_ack_c2", 32'(cpu_ack), 32'h0);
        tick();
        check("s1_ack_c3", 32'({cpu_ack, ld_ack}), 32'b10);
        check("s1_rdata", 32'(cpu_rdata), 32'hAB);
        cpu_req = 1'b0;
        tick();
        check("s1_ack_gone", 32'(cpu_ack), 32'h0);
        check("s1_idle_ce", 32'(sram_ce_n), 32'h1);
        tick();
        check("s1_rdata_hold", 32'(cpu_rdata), 32'hAB);

        // 384KiB upper half: 0xA0001 -> byte 0x40001 -> word 0x20000, high lane
        romsel = 3'b001; cpu_addr = 20'hA0001; cpu_req = 1'b1;
        tick();
        check("s2_addr", 32'(sram_addr), 32'h20000);
        wait_cpu_ack(n);
        check("s2_lat", 32'(n), 32'd2);
        check("s2_rdata", 32'(cpu_rdata), 32'h3C);
        cpu_req = 1'b0;
        tick();

        // 384KiB lower half boundary: 0x7FFFE -> word 0x1FFFF, low lane
        cpu_addr = 20'h7FFFE; cpu_req = 1'b1;
        tick();
        check("s2b_addr", 32'(sram_addr), 32'h1FFFF);
        wait_cpu_ack(n);
        check("s2b_rdata", 32'(cpu_rdata), 32'hEF);
        cpu_req = 1'b0;
        tick();

        // 256KiB with romsel changed mid-access: mapping stays 256KiB
        romsel = 3'b000; cpu_addr = 20'hC5678; cpu_req = 1'b1;
        tick();
        romsel = 3'b011;
        tick();
        check("s3_addr_kept", 32'(sram_addr), 32'h02B3C);
        wait_cpu_ack(n);
        check("s3_lat", 32'(n), 32'd1);
        check("s3_rdata", 32'(cpu_rdata), 32'h22);
        cpu_req = 1'b0;
        tick();

        // Loader write 0x5A5A to word 0x00010
        ld_we = 1'b1; ld_addr = 19'h00010; ld_wdata = 16'h5A5A; ld_req = 1'b1;
        we_low = 0; oe_hi = 0; lacks = 0; cacks = 0; addr_seen = 20'hFFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!sram_we_n) we_low++;
            if (sram_dq_oe) oe_hi++;
            if (cpu_ack) cacks++;
            if (!sram_ce_n && addr_seen == 20'hFFFFF) addr_seen = sram_addr;
            if (ld_ack) begin
                lacks++;
                ld_req = 1'b0;
            end
        end
        check("w_we_low", 32'(we_low), 32'd1);
        check("w_oe_hi", 32'(oe_hi), 32'd2);
        check("w_ld_ack", 32'(lacks), 32'd1);
        check("w_cpu_ack", 32'(cacks), 32'd0);
        check("w_addr", 32'(addr_seen), 32'h00010);

        // Loader readback of the same word
        ld_we = 1'b0; ld_req = 1'b1;
        wait_ld_ack(n);
        check("r_lat", 32'(n), 32'd3);
        check("r_rdata", 32'(ld_rdata), 32'h5A5A);
        ld_req = 1'b0;
        tick();

        // Both ports held: fair alternates CPU/loader/CPU, else CPU only
        rst = 1'b1;
        tick();
        rst = 1'b0;
        romsel = 3'b011; cpu_addr = 20'h12345; cpu_req = 1'b1; ld_req = 1'b1;
        order = 3'b111; k = 0; lacks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cpu_ack && k < 3) begin
                order[k] = 1'b0;
                k++;
            end
            if (ld_ack) begin
                lacks++;
                if (k < 3) begin
                    order[k] = 1'b1;
                    k++;
                end
            end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
`ifdef ARB_FAIR_EN
        check("arb_order", 32'(order), 32'b010);
        check("arb_ld_grants", 32'(lacks), 32'd1);
`else
        check("arb_order", 32'(order), 32'b000);
        check("arb_ld_grants", 32'(lacks), 32'd0);
`endif
        for (int i = 0; i < 6; i++) tick();

        // Reset in the middle of ACCESS
        cpu_addr = 20'h12345; cpu_req = 1'b1;
        tick();
        check("ra_ce_active", 32'(sram_ce_n), 32'h0);
        rst = 1'b1;
        #1;
        check("ra_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                                 sram_dq_oe}), 32'b111110);
        check("ra_addr", 32'(sram_addr), 32'h0);
        check("ra_rdata", 32'(cpu_rdata), 32'h0);
        tick();
        check("ra_no_ack", 32'({cpu_ack, ld_ack}), 32'b00);
        rst = 1'b0;
        wait_cpu_ack(n);
        check("ra_regrant_lat", 32'(n), 32'd3);
        check("ra_rdata_after", 32'(cpu_rdata), 32'hAB);
        cpu_req = 1'b0;
        tick();

        // WAIT_CYCLES=3: ACCESS 4 cycles, ack 5 cycles after request
        romsel3 = 3'b011; cpu_addr3 = 20'h00002; cpu_req3 = 1'b1;
        ce_low = 0; ack_at = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (!ce3_n) ce_low++;
            if (cpu_ack3 && ack_at < 0) begin
                ack_at = i;
                cpu_req3 = 1'b0;
            end
        end
        check("w3_access_len", 32'(ce_low), 32'd4);
        check("w3_ack_at", 32'(ack_at), 32'd5);
        check("w3_rdata", 32'(cpu_rdata3), 32'h34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
